// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Purpose : Types and default constants shared by the UART receiver and
//           transmitter.
// Contents: uart_rx_state_t   receiver FSM state encoding
//           UART_CLKS_PER_BIT default clk cycles per bit period
//           UART_DATA_BITS    default data bits per frame
// Revision: 1.0  initial release
// ============================================================================
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 16;
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_rx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
// Module  : uart_sync2
// Purpose : Two-flop synchronizer for an asynchronous single-bit input.
//           Both flops reset to 1 so an idle-high line reads idle out of reset.
// Ports   : clk  in   clock
//           rst  in   synchronous active-high reset
//           d    in   asynchronous input
//           q    out  synchronized output (two clk cycles of latency)
// Revision: 1.0  initial release
// ============================================================================
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : uart_sync2
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx
// Purpose : UART serial receiver. Synchronizes rxd, detects the start bit,
//           samples data bits at mid-bit (LSB first), checks the stop bit and
//           presents each good word with a one-cycle valid strobe. No
//           buffering: the consumer must take rxd_data on the strobe cycle.
// Config  : UART_RX_PARITY_EN - when defined, an even parity bit follows the
//           data bits and the parity_err output is present.
// Params  : CLKS_PER_BIT  clk cycles per bit (even, >= 4)
//           DATA_BITS     data bits per frame (5..9)
// Ports   : clk         in   clock
//           rst         in   synchronous active-high reset
//           rxd         in   asynchronous serial line, idles high
//           rxd_data    out  last correctly framed word
//           rxd_valid   out  one-cycle pulse when rxd_data was updated
//           frame_err   out  one-cycle pulse when stop bit sampled low
//           busy        out  high while the FSM is not in IDLE
//           parity_err  out  one-cycle pulse on parity mismatch (option)
// Revision: 1.0  initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rxd_data,
  output logic                 rxd_valid,
  output logic                 frame_err,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 rxd_s;
  uart_rx_state_t       state;
  uart_rx_state_t       state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shreg;

  logic cnt_half;
  logic cnt_full;
  logic valid_nxt;
  logic ferr_nxt;
  logic busy_nxt;

  assign cnt_half = (cnt == CNT_HALF);
  assign cnt_full = (cnt == CNT_LAST);

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!rxd_s) state_nxt = START;
      // A start bit that is high again at mid-bit was a glitch.
      START: if (cnt_half) state_nxt = rxd_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:   if (cnt_full && (idx == IDX_LAST)) state_nxt = PARITY;
      PARITY: if (cnt_full) state_nxt = STOP;
`else
      DATA:   if (cnt_full && (idx == IDX_LAST)) state_nxt = STOP;
`endif
      STOP:  if (cnt_full) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode (next values of the registered outputs)
  // --------------------------------------------------------------------------
  always_comb begin
    valid_nxt = (state == STOP) && cnt_full && rxd_s;
    ferr_nxt  = (state == STOP) && cnt_full && !rxd_s;
    busy_nxt  = (state_nxt != IDLE);
  end

  // --------------------------------------------------------------------------
  // Datapath and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      rxd_data  <= '0;
      rxd_valid <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // The counter restarts on every state change and at every bit boundary.
      if ((state == IDLE) || (state_nxt != state) || cnt_full) cnt <= '0;
      else                                                     cnt <= cnt + CNT_W'(1);

      if (state != DATA)  idx <= '0;
      else if (cnt_full)  idx <= idx + IDX_W'(1);

      // LSB arrives first, so shifting in at the MSB leaves bit 0 at the
      // bottom once all DATA_BITS samples are in.
      if ((state == DATA) && cnt_full) shreg <= {rxd_s, shreg[DATA_BITS-1:1]};

      if (valid_nxt) rxd_data <= shreg;

      rxd_valid <= valid_nxt;
      frame_err <= ferr_nxt;
      busy      <= busy_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity verdict is captured in PARITY and reported with the stop result,
  // so parity_err lines up with rxd_valid / frame_err.
  logic par_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if ((state == PARITY) && cnt_full) par_bad <= (^shreg) ^ rxd_s;
      parity_err <= (state == STOP) && cnt_full && par_bad;
    end
  end
`endif

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx
// Purpose : Self-checking bench for uart_rx at default parameters. Optional
//           parity cases are built when UART_RX_PARITY_EN is defined.
// Revision: 1.0  initial release
// ============================================================================
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  // Edges from first low sample of rxd to the result pulse; frame length.
  localparam int LAT   = 2 + CPB / 2 + (DB + P + 1) * CPB;
  localparam int FRAME = (DB + P + 2) * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rxd = 1'b1;
  logic [DB-1:0] rxd_data;
  logic          rxd_valid;
  logic          frame_err;
  logic          busy;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
`endif

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .rxd_data   (rxd_data),
    .rxd_valid  (rxd_valid),
    .frame_err  (frame_err),
    .busy       (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Pulse monitor: samples 1 time unit after each rising edge.
  int            vcnt = 0;
  int            fcnt = 0;
  int            pcnt = 0;
  int            vcyc[$];
  logic [DB-1:0] vdat[$];

  always @(posedge clk) begin
    #1;
    if (rxd_valid) begin
      vcnt++;
      vcyc.push_back(cyc);
      vdat.push_back(rxd_data);
    end
    if (frame_err) fcnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pcnt++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drives one frame starting at a falling edge; st is the cycle count seen
  // right after the first rising edge that samples the start bit.
  task automatic send(input logic [7:0] d, input logic stop_bit,
                      input logic par_flip, output int st);
    rxd = 1'b0;
    st  = cyc + 1;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rxd = d[i];
      repeat (CPB) @(negedge clk);
    end
    if (P == 1) begin
      rxd = (^d) ^ par_flip;
      repeat (CPB) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
  endtask

  int st0;
  int st1;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data",  32'(rxd_data),  32'h0);
    check("rst_valid", 32'(rxd_valid), 32'h0);
    check("rst_ferr",  32'(frame_err), 32'h0);
    check("rst_busy",  32'(busy),      32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single good frame 0xA5 with latency check.
    send(8'hA5, 1'b1, 1'b0, st0);
    repeat (5) @(negedge clk);
    check("a5_vcnt", 32'(vcnt), 32'd1);
    check("a5_lat",  32'(vcyc[0] - st0), 32'(LAT));
    check("a5_vdat", 32'(vdat[0]), 32'hA5);
    check("a5_data", 32'(rxd_data), 32'hA5);
    check("a5_ferr", 32'(fcnt), 32'd0);
    check("a5_busy", 32'(busy), 32'h0);

    // 0x5A with stop bit low: one frame error, data held.
    send(8'h5A, 1'b0, 1'b0, st0);
    repeat (40) @(negedge clk);
    check("fe_ferr", 32'(fcnt), 32'd1);
    check("fe_vcnt", 32'(vcnt), 32'd1);
    check("fe_data", 32'(rxd_data), 32'hA5);
    check("fe_busy", 32'(busy), 32'h0);

    // Four-cycle start glitch, then a real 0x3C frame.
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    check("gl_busy_hi", 32'(busy), 32'h1);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    check("gl_busy_lo", 32'(busy), 32'h0);
    check("gl_vcnt", 32'(vcnt), 32'd1);
    check("gl_ferr", 32'(fcnt), 32'd1);
    send(8'h3C, 1'b1, 1'b0, st0);
    repeat (5) @(negedge clk);
    check("3c_vcnt", 32'(vcnt), 32'd2);
    check("3c_data", 32'(rxd_data), 32'h3C);

    // Back-to-back 0x00 and 0xFF with a single stop bit each.
    vcyc.delete();
    vdat.delete();
    send(8'h00, 1'b1, 1'b0, st0);
    send(8'hFF, 1'b1, 1'b0, st1);
    repeat (5) @(negedge clk);
    check("b2b_n",    32'(vdat.size()), 32'd2);
    check("b2b_d0",   32'(vdat[0]), 32'h00);
    check("b2b_d1",   32'(vdat[1]), 32'hFF);
    check("b2b_gap",  32'(vcyc[1] - vcyc[0]), 32'(FRAME));
    check("b2b_ferr", 32'(fcnt), 32'd1);

    // Reset during bit 3 of a frame.
    rxd = 1'b0;                        // start
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;                        // bit 0
    repeat (CPB) @(negedge clk);
    rxd = 1'b0;                        // bits 1, 2 and into bit 3
    repeat (2 * CPB + CPB / 2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mr_data",  32'(rxd_data),  32'h0);
    check("mr_valid", 32'(rxd_valid), 32'h0);
    check("mr_ferr",  32'(frame_err), 32'h0);
    check("mr_busy",  32'(busy),      32'h0);
    @(negedge clk);
    rst = 1'b0;
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    check("mr_vcnt", 32'(vcnt), 32'd4);
    check("mr_fcnt", 32'(fcnt), 32'd1);
    send(8'h81, 1'b1, 1'b0, st0);
    repeat (5) @(negedge clk);
    check("81_vcnt", 32'(vcnt), 32'd5);
    check("81_data", 32'(rxd_data), 32'h81);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: parity bit 0 is wrong, parity bit 1 is right.
    send(8'h07, 1'b1, 1'b1, st0);
    repeat (5) @(negedge clk);
    check("pe_pcnt", 32'(pcnt), 32'd1);
    check("pe_vcnt", 32'(vcnt), 32'd6);
    check("pe_data", 32'(rxd_data), 32'h07);
    send(8'h07, 1'b1, 1'b0, st0);
    repeat (5) @(negedge clk);
    check("po_pcnt", 32'(pcnt), 32'd1);
    check("po_vcnt", 32'(vcnt), 32'd7);
`else
    check("np_pcnt", 32'(pcnt), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_rx
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART link; the receive-side counterpart of the team's UART transmitter. It synchronizes the asynchronous `rxd` line, detects start bits, samples each data bit at mid-bit, checks the stop bit and presents each received word with a one-cycle valid strobe. It sits between the pad-side `rxd` pin and the consumer logic, which must accept every word on the strobe cycle because there is no buffering or backpressure.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: `clk` cycles per bit period; even, ≥ 4.
- `DATA_BITS`, default 8: data bits per frame, 5..9, sent LSB first.

Ports:
- `clk`  input  1  the single clock; all logic is on the rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `rxd`  input  1  asynchronous serial line; idles high.
- `rxd_data`  output  DATA_BITS  last correctly framed word; holds until the next good frame.
- `rxd_valid`  output  1  one-cycle pulse when `rxd_data` has just been updated.
- `frame_err`  output  1  one-cycle pulse when the stop bit is sampled low.
- `busy`  output  1  high whenever the FSM is not in IDLE.
- `parity_err`  output  1  one-cycle pulse on parity mismatch; present only with `UART_RX_PARITY_EN`.

## Operation
- `rxd` passes through two flops. The synchronizer resets to 1, and the FSM sees only the second flop output (`rxd_s`).
- A bit counter (width clog2(CLKS_PER_BIT)) and a bit index (width clog2(DATA_BITS+1)) control sampling.
- FSM states:
  - IDLE: counter = 0. If `rxd_s` == 0, go to START.
  - START: count to CLKS_PER_BIT/2−1. At that point, if `rxd_s` == 0, go to DATA with counter and index at 0. Otherwise the low was a glitch and the FSM returns to IDLE with no output pulse.
  - DATA: at counter == CLKS_PER_BIT−1, shift `rxd_s` into the MSB of the shift register (LSB first on the line), increment the index and clear the counter. After DATA_BITS samples, go to STOP, or to PARITY when the macro is enabled.
  - PARITY (macro only): sample one bit at counter == CLKS_PER_BIT−1, then go to STOP.
  - STOP: sample at counter == CLKS_PER_BIT−1.
    - Sample 1: load `rxd_data` from the shift register and pulse `rxd_valid`.
    - Sample 0: pulse `frame_err` and leave `rxd_data` unchanged.
    - In both cases, go to IDLE on the same edge.
- All outputs are registered, and the pulses last exactly one cycle.
- A new start bit is recognized from the first cycle in IDLE, so back-to-back frames with a single stop bit are received.
- A line held low (break) produces `frame_err` once and is then re-detected as a start bit. Each resulting frame produces a further `frame_err`, and this repeats until the line returns high.

## Timing
- Reset values:
  - `rxd_data` = 0; `rxd_valid`, `frame_err`, `parity_err` and `busy` = 0.
  - FSM in IDLE; counter and index at 0; synchronizer flops at 1.
- Reset mid-frame aborts the frame with no pulse. Reception restarts from IDLE on the first edge after `rst` falls.
- Latency: count from the first edge that samples `rxd` low. `rxd_valid` or `frame_err` rises 2 + CLKS_PER_BIT/2 + (DATA_BITS+P+1)·CLKS_PER_BIT edges later, where P = 1 with the macro and 0 without. At the defaults this is 154 edges.
- `busy` rises one edge after `rxd_s` is first low and falls on the same edge as the result pulse.
- With the parity macro, `rxd_valid` and `parity_err` may pulse together. Both `frame_err` and `parity_err` may also pulse together.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Adds the PARITY state and the `parity_err` port.
  - Parity is even: the XOR of the data bits and the parity bit must be 0.
  - Data is still delivered on `rxd_valid` when parity fails.
- Macro undefined: no PARITY state, no `parity_err` port, and frames are start + DATA_BITS + stop.

## Structure
- Package `uart_pkg`:
  - `uart_rx_state_t` enum: IDLE, START, DATA, PARITY, STOP.
  - Default constants `UART_CLKS_PER_BIT` = 16 and `UART_DATA_BITS` = 8, shared with the transmitter.
- Sub-module `uart_sync2`: the two-flop synchronizer with reset value 1. It is reusable for other asynchronous inputs.

## Test plan
- Defaults, send 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop) → exactly one `rxd_valid` pulse at edge 154, `rxd_data` = 0xA5, `frame_err` stays 0.
- Start glitch: `rxd` low for 4 cycles → no pulse, `busy` returns to 0 and the FSM is in IDLE. A following 0x3C frame is received correctly.
- Frame 0x5A with the stop bit held low → `frame_err` pulses once, `rxd_data` keeps its previous value 0xA5, no `rxd_valid`.
- Back-to-back 0x00 then 0xFF, one stop bit each → two `rxd_valid` pulses, 160 edges apart, with data 0x00 then 0xFF.
- Assert `rst` during bit 3 of a frame → all outputs 0 on the next edge, no pulse. A subsequent 0x81 frame is received.
- With `UART_RX_PARITY_EN`, send 0x07 with parity bit 0 → `rxd_valid` and `parity_err` both pulse, `rxd_data` = 0x07. Parity bit 1 → no `parity_err`.
